// File: rtl/slice_logic_unit_if.sv
// Start/operand/result bundle between the ALU sequencer and slice_logic_unit.
// The parity signal and its modport entries exist only when LOGIC_PARITY_EN is defined.
interface slice_logic_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
`ifdef LOGIC_PARITY_EN
  logic             parity;

  modport master (output start, op, a, b, input busy, done, result, zero, parity);
  modport slave  (input start, op, a, b, output busy, done, result, zero, parity);
`else
  modport master (output start, op, a, b, input busy, done, result, zero);
  modport slave  (input start, op, a, b, output busy, done, result, zero);
`endif
endinterface

// File: rtl/slice_logic_unit.sv
// Multi-cycle AND/OR/XOR/NOR unit: WIDTH-bit operands processed LSB-first, CHUNK bits per clock.
// Optional parity flag enabled by defining LOGIC_PARITY_EN.
module slice_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input logic               clk,
  input logic               rst_n,
  slice_logic_unit_if.slave bus
);
  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_zero;
  logic [31:0]      w_base;
  logic [WIDTH-1:0] w_opres;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_final;
`ifdef LOGIC_PARITY_EN
  logic             r_parity;
`endif

  // Next state; start is honoured only in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_cnt == CW'(N - 1));
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Whole-word op, then only the current slice is merged into the result
  always_comb begin
    w_opres = '0;
    case (r_op)
      2'b00:   w_opres = r_a & r_b;
      2'b01:   w_opres = r_a | r_b;
      2'b10:   w_opres = r_a ^ r_b;
      default: w_opres = ~(r_a | r_b);
    endcase
    w_base  = 32'(r_cnt) * CHUNK;
    w_mask  = WIDTH'({CHUNK{1'b1}}) << w_base;
    w_final = r_result | (w_opres & w_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
`ifdef LOGIC_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_BUSY);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_a      <= bus.a;
        r_b      <= bus.b;
        r_op     <= bus.op;
        r_result <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_BUSY) begin
        r_result <= w_final;
        r_cnt    <= r_cnt + CW'(1);
        // Flags change only once the full word is known
        if (w_last) begin
          r_zero   <= (w_final == '0);
`ifdef LOGIC_PARITY_EN
          r_parity <= ^w_final;
`endif
        end
      end
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
`ifdef LOGIC_PARITY_EN
  assign bus.parity = r_parity;
`endif

endmodule

// File: tb/tb_slice_logic_unit.sv
// Bench for slice_logic_unit: vector table with done-driven scoreboard, plus held-start,
// back-to-back, mid-op reset and N=1 / N=4 latency sequences.
module tb_slice_logic_unit;
  logic clk;
  logic rst_n;

  slice_logic_unit_if #(.WIDTH(32)) bus0 ();
  slice_logic_unit_if #(.WIDTH(32)) bus1 ();
  slice_logic_unit_if #(.WIDTH(32)) bus4 ();

  slice_logic_unit #(.WIDTH(32), .CHUNK(4))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus0));
  slice_logic_unit #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  slice_logic_unit #(.WIDTH(32), .CHUNK(8))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  logic        st0, st1, st4;
  logic [31:0] a, b;
  logic [1:0]  op;

  assign bus0.start = st0; assign bus0.a = a; assign bus0.b = b; assign bus0.op = op;
  assign bus1.start = st1; assign bus1.a = a; assign bus1.b = b; assign bus1.op = op;
  assign bus4.start = st4; assign bus4.a = a; assign bus4.b = b; assign bus4.op = op;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        p;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        p;
  } exp_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: every done pulse of the main unit consumes one expected record
  always @(negedge clk) begin
    if (rst_n && bus0.done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", bus0.result, e.res);
        check("sb_zero", 32'(bus0.zero), 32'(e.z));
`ifdef LOGIC_PARITY_EN
        check("sb_parity", 32'(bus0.parity), 32'(e.p));
`endif
      end
    end
  end

  // One operation on the main unit with start pulsed once and operands scrambled mid-op
  task automatic run_main(input vec_t v);
    int cyc;
    int nbusy;
    bit seen;
    a = v.a; b = v.b; op = v.op; st0 = 1'b1;
    sb_q.push_back('{v.res, v.z, v.p});
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        st0 = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
      end
      if (bus0.busy) nbusy++;
      if (bus0.done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(cyc - 1), 32'd8);
    check("busy_cycles", 32'(nbusy), 32'd8);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [31:0] m;

    vecs[0] = '{2'b10, 32'hA5A5_0F0F, 32'hFFFF_0F0F, 32'h5A5A_0000, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{2'b11, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4] = '{2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1};
    vecs[7] = '{2'b11, 32'hFFFF_0000, 32'h0000_FFF0, 32'h0000_000F, 1'b0, 1'b0};

    // Reset with start held high
    rst_n = 1'b0; st0 = 1'b1; st1 = 1'b0; st4 = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 2'b10;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_done", 32'(bus0.done), 32'd0);
    check("rst_result", bus0.result, 32'd0);
    check("rst_zero", 32'(bus0.zero), 32'd0);
`ifdef LOGIC_PARITY_EN
    check("rst_parity", 32'(bus0.parity), 32'd0);
`endif
    rst_n = 1'b1; st0 = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(bus0.busy), 32'd0);
    check("idle_result", bus0.result, 32'd0);

    for (int i = 0; i < NV; i++) run_main(vecs[i]);

    // Start held through BUSY with churning operands, then back-to-back OR from DONE
    a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; op = 2'b00; st0 = 1'b1;
    sb_q.push_back('{32'hF000_F000, 1'b0, 1'b0});
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus0.done) seen = 1'b1;
      else begin a = $urandom; b = $urandom; op = 2'($urandom); end
    end
    check("held_done_seen", 32'(seen), 32'd1);
    check("held_latency", 32'(cyc - 1), 32'd8);
    a = 32'hF0F0_F0F0; b = 32'hFF00_FF00; op = 2'b01;
    sb_q.push_back('{32'hFFF0_FFF0, 1'b0, 1'b0});
    @(negedge clk);
    check("b2b_busy", 32'(bus0.busy), 32'd1);
    check("b2b_cleared", bus0.result, 32'd0);
    st0 = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m = (k == 7) ? 32'hFFFF_FFFF : ((32'd1 << (4 * (k + 1))) - 32'd1);
      check("b2b_slice", bus0.result, 32'hFFF0_FFF0 & m);
      if (k < 7) check("b2b_busy_k", 32'(bus0.busy), 32'd1);
      else       check("b2b_done_gap9", 32'(bus0.done), 32'd1);
    end
    @(negedge clk);

    // Reset during the 4th BUSY cycle
    a = 32'h0; b = 32'h0; op = 2'b11; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_partial", bus0.result, 32'h0000_0FFF);
    #2 rst_n = 1'b0; st0 = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus0.busy), 32'd0);
    check("async_rst_result", bus0.result, 32'd0);
    check("async_rst_zero", 32'(bus0.zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; st0 = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_busy", 32'(bus0.busy), 32'd0);
    check("post_rst_result", bus0.result, 32'd0);
    run_main(vecs[0]);

    // N = 1 latency
    a = 32'hA5A5_0F0F; b = 32'hFFFF_0F0F; op = 2'b10; st1 = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (cyc == 1) st1 = 1'b0;
      if (bus1.done) seen = 1'b1;
    end
    check("n1_done_seen", 32'(seen), 32'd1);
    check("n1_latency", 32'(cyc - 1), 32'd1);
    check("n1_result", bus1.result, 32'h5A5A_0000);

    // N = 4 latency
    a = 32'h0000_0000; b = 32'h0000_0000; op = 2'b11; st4 = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk); cyc++;
      if (cyc == 1) st4 = 1'b0;
      if (bus4.done) seen = 1'b1;
    end
    check("n4_done_seen", 32'(seen), 32'd1);
    check("n4_latency", 32'(cyc - 1), 32'd4);
    check("n4_result", bus4.result, 32'hFFFF_FFFF);
    check("n4_zero", 32'(bus4.zero), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200us");
    $fatal(1);
  end

endmodule
